// File: rtl/beam_stream_driver_if.sv
// Byte-stream input and result handshake bundle for beam_stream_driver.
// The master side feeds grid bytes and takes results; the slave side is the driver.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface beam_stream_driver_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [7:0]            in_byte;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] split_count;
    logic                  result_valid;
    logic                  result_ready;
    logic                  error;

    modport master (
        output in_valid, in_last, in_byte, result_ready,
        input  in_ready, result, split_count, result_valid, error
    );

    modport slave (
        input  in_valid, in_last, in_byte, result_ready,
        output in_ready, result, split_count, result_valid, error
    );
endinterface

// File: rtl/beam_stream_driver.sv
// Parses an ASCII beam grid byte stream, steps a downstream beam splitter one column per byte,
// then sweeps one line of columns to total the surviving beams and hands the result off.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module beam_stream_driver #(
    parameter int LINE_LENGTH = 141,
    parameter int DATA_WIDTH  = `DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    beam_stream_driver_if.slave   bus,
    output logic                  spl_en,
    output logic                  spl_split,
    output logic                  spl_clear,
    input  logic [DATA_WIDTH-1:0] count_in
);

    localparam int COL_W = $clog2(LINE_LENGTH + 1);
    localparam int SUM_W = $clog2(LINE_LENGTH);

    localparam logic [COL_W-1:0] COL_FULL = COL_W'(LINE_LENGTH);
    localparam logic [COL_W-1:0] COL_MID  = COL_W'(LINE_LENGTH / 2);
    localparam logic [SUM_W-1:0] SUM_LAST = SUM_W'(LINE_LENGTH - 1);

    localparam logic [7:0] BYTE_LF    = 8'h0A;
    localparam logic [7:0] BYTE_CR    = 8'h0D;
    localparam logic [7:0] BYTE_DOT   = 8'h2E;
    localparam logic [7:0] BYTE_START = 8'h53;
    localparam logic [7:0] BYTE_SPLIT = 8'h5E;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        SUM,
        DONE,
        CLEAR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      col_next;
    logic                  first_line;
    logic                  pulse_q;
    logic                  pulse_split_q;
    logic [SUM_W-1:0]      sum_cnt;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] split_count_q;
    logic                  error_q;

    logic                  accept;
    logic                  is_lf;
    logic                  is_cr;
    logic                  is_column;
    logic                  col_full;
    logic                  col_step;
    logic                  byte_split;
    logic                  byte_error;
    logic                  last_error;
    logic                  count_split;

    // Byte decode: what the accepted byte does to the column position and the sticky error.
    always_comb begin
        accept     = (state == RUN) && bus.in_valid;
        is_lf      = (bus.in_byte == BYTE_LF);
        is_cr      = (bus.in_byte == BYTE_CR);
        is_column  = !is_lf && !is_cr;
        col_full   = (col == COL_FULL);
        byte_split = (bus.in_byte == BYTE_SPLIT);
        col_next   = col;
        col_step   = 1'b0;
        byte_error = 1'b0;

        if (is_lf) begin
            col_next   = '0;
            byte_error = !col_full;
        end else if (is_column) begin
            if (col_full) begin
                byte_error = 1'b1;
            end else begin
                col_next = col + COL_W'(1);
                col_step = 1'b1;
            end

            if (bus.in_byte == BYTE_START) begin
                if ((col != COL_MID) || !first_line) begin
                    byte_error = 1'b1;
                end
            end else if ((bus.in_byte != BYTE_DOT) && !byte_split) begin
                byte_error = 1'b1;
            end
        end

        last_error = bus.in_last && (col_next != '0) && (col_next != COL_FULL);
    end

    // A split only counts if the splitter actually had a beam in that column.
    always_comb begin
        count_split = ((state == RUN) || (state == DRAIN)) &&
                      spl_en && spl_split && (count_in != '0);
    end

    always_comb begin
        state_next       = state;
        bus.in_ready     = 1'b0;
        bus.result_valid = 1'b0;
        spl_en           = pulse_q;
        spl_split        = pulse_split_q;
        spl_clear        = 1'b0;

        case (state)
            RUN: begin
                bus.in_ready = 1'b1;
                if (accept && bus.in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = SUM;
            end
            SUM: begin
                spl_en    = 1'b1;
                spl_split = 1'b0;
                if (sum_cnt == SUM_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                spl_clear  = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col           <= '0;
            first_line    <= 1'b1;
            pulse_q       <= 1'b0;
            pulse_split_q <= 1'b0;
            sum_cnt       <= '0;
            result_q      <= '0;
            split_count_q <= '0;
            error_q       <= 1'b0;
        end else begin
            pulse_q       <= accept && col_step;
            pulse_split_q <= accept && col_step && byte_split;

            if (accept) begin
                col <= col_next;
                if (is_lf) begin
                    first_line <= 1'b0;
                end
                if (byte_error || last_error) begin
                    error_q <= 1'b1;
                end
            end

            if (count_split) begin
                split_count_q <= split_count_q + DATA_WIDTH'(1);
            end

            // The sweep restarts from zero; the last byte's pulse is still in flight in DRAIN.
            if (state == DRAIN) begin
                result_q <= '0;
                sum_cnt  <= '0;
            end

            if (state == SUM) begin
                result_q <= result_q + count_in;
                sum_cnt  <= sum_cnt + SUM_W'(1);
            end

            if (state == CLEAR) begin
                col           <= '0;
                first_line    <= 1'b1;
                split_count_q <= '0;
                error_q       <= 1'b0;
            end
        end
    end

    assign bus.result      = result_q;
    assign bus.split_count = split_count_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_beam_stream_driver.sv
// Directed bench for beam_stream_driver with a behavioural beam splitter model feeding count_in.
// Grid streams with hand-worked totals are run from a table, plus a few multi-cycle sequences.
module tb_beam_stream_driver;

    localparam int LL        = 5;
    localparam int DW        = 16;
    localparam int NUM_CASES = 11;
    localparam int TEXT_B    = 20;

    typedef struct {
        logic [8*TEXT_B-1:0] text;
        int                  run_pulses;
        logic [DW-1:0]       exp_result;
        logic [DW-1:0]       exp_split;
        logic                exp_error;
    } vec_t;

    logic          clock;
    logic          reset;
    logic          spl_en;
    logic          spl_split;
    logic          spl_clear;
    logic [DW-1:0] count_in;

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;

    vec_t vectors [NUM_CASES];

    beam_stream_driver_if #(.DATA_WIDTH(DW)) bus ();

    beam_stream_driver #(
        .LINE_LENGTH(LL),
        .DATA_WIDTH (DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .spl_en   (spl_en),
        .spl_split(spl_split),
        .spl_clear(spl_clear),
        .count_in (count_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Splitter model: one beam enters at the middle column; a split moves a column's count to its neighbours.
    logic [DW-1:0] cnt [LL];
    int            pos = 0;

    always @(posedge clock) begin
        if (reset || spl_clear) begin
            for (int i = 0; i < LL; i++) begin
                cnt[i] <= (i == LL / 2) ? DW'(1) : DW'(0);
            end
            pos <= 0;
        end else if (spl_en) begin
            if (spl_split) begin
                if (pos > 0) cnt[pos-1] <= cnt[pos-1] + cnt[pos];
                if (pos < LL - 1) cnt[pos+1] <= cnt[pos+1] + cnt[pos];
                cnt[pos] <= '0;
            end
            pos <= (pos == LL - 1) ? 0 : pos + 1;
        end
    end

    assign count_in = cnt[pos];

    always @(posedge clock) begin
        if (spl_en) pulse_total <= pulse_total + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int textLen(input logic [8*TEXT_B-1:0] t);
        int n = 0;
        for (int k = 0; k < TEXT_B; k++) begin
            if (t[8*k +: 8] != 8'h00) n = k + 1;
        end
        return n;
    endfunction

    task automatic setVec(input int idx, input logic [8*TEXT_B-1:0] t, input int pulses,
                          input int res, input int spl, input logic err);
        vectors[idx].text       = t;
        vectors[idx].run_pulses = pulses;
        vectors[idx].exp_result = DW'(res);
        vectors[idx].exp_split  = DW'(spl);
        vectors[idx].exp_error  = err;
    endtask

    // Called at a negedge; leaves the bench at the negedge of the cycle after the last byte.
    task automatic applyStimulus(input logic [8*TEXT_B-1:0] t);
        int len = textLen(t);
        for (int i = 0; i < len; i++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = t[8*(len-1-i) +: 8];
            bus.in_last  = (i == len - 1);
            @(posedge clock);
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_byte  = 8'h00;
    endtask

    task automatic waitDone(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic handshake();
        bus.result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.result_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic runCase(input int i);
        int   start;
        logic ok;
        start = pulse_total;
        applyStimulus(vectors[i].text);
        waitDone(ok);
        checkOutput($sformatf("case%0d done", i), 32'(ok), 32'd1);
        checkOutput($sformatf("case%0d result", i), 32'(bus.result), 32'(vectors[i].exp_result));
        checkOutput($sformatf("case%0d split_count", i), 32'(bus.split_count), 32'(vectors[i].exp_split));
        checkOutput($sformatf("case%0d error", i), 32'(bus.error), 32'(vectors[i].exp_error));
        checkOutput($sformatf("case%0d spl_en pulses", i), 32'(pulse_total - start),
                    32'(vectors[i].run_pulses + LL));
        handshake();
    endtask

    initial begin
        logic                ok;
        logic                stable;
        logic [8*TEXT_B-1:0] t;

        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_byte      = 8'h00;
        bus.in_last      = 1'b0;
        bus.result_ready = 1'b0;

        setVec(0,  "..S..\n..^..\n.....",   15, 2, 1, 1'b0);
        setVec(1,  "..S..\n..^..\n.^.^.\n", 15, 4, 3, 1'b0);
        setVec(2,  "..S..\n^....\n",        10, 1, 0, 1'b0);
        setVec(3,  "....\n",                 4, 1, 0, 1'b1);
        setVec(4,  "..x..\n",                5, 1, 0, 1'b1);
        setVec(5,  "..S..\r\n..^..\n",      10, 2, 1, 1'b0);
        setVec(6,  ".S...\n",                5, 1, 0, 1'b1);
        setVec(7,  "......\n",               5, 1, 0, 1'b1);
        setVec(8,  "..S..\n..S..\n",        10, 1, 0, 1'b1);
        setVec(9,  "..S..",                  5, 1, 0, 1'b0);
        setVec(10, "..S",                    3, 1, 0, 1'b1);

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("reset spl_en", 32'(spl_en), 32'd0);
        checkOutput("reset spl_split", 32'(spl_split), 32'd0);
        checkOutput("reset spl_clear", 32'(spl_clear), 32'd0);
        checkOutput("reset result", 32'(bus.result), 32'd0);
        checkOutput("reset split_count", 32'(bus.split_count), 32'd0);
        checkOutput("reset error", 32'(bus.error), 32'd0);

        // One-cycle pulse latency for '.' then '^'.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h2E;
        @(posedge clock);
        @(negedge clock);
        checkOutput("dot pulse spl_en", 32'(spl_en), 32'd1);
        checkOutput("dot pulse spl_split", 32'(spl_split), 32'd0);
        bus.in_byte = 8'h5E;
        @(posedge clock);
        @(negedge clock);
        checkOutput("caret pulse spl_en", 32'(spl_en), 32'd1);
        checkOutput("caret pulse spl_split", 32'(spl_split), 32'd1);
        bus.in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("idle spl_en", 32'(spl_en), 32'd0);
        doReset();

        for (int i = 0; i < NUM_CASES; i++) begin
            runCase(i);
        end

        // DONE stall with an errored stream, then the clear cycle.
        t = "..S..\n..^..\n....x";
        applyStimulus(t);
        waitDone(ok);
        checkOutput("stall done", 32'(ok), 32'd1);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(bus.result_valid === 1'b1 && bus.result === DW'(2) && bus.split_count === DW'(1) &&
                  bus.error === 1'b1 && spl_en === 1'b0)) stable = 1'b0;
            @(negedge clock);
        end
        checkOutput("stall outputs stable", 32'(stable), 32'd1);
        checkOutput("stall result", 32'(bus.result), 32'd2);
        bus.result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.result_ready = 1'b0;
        checkOutput("clear spl_clear", 32'(spl_clear), 32'd1);
        checkOutput("clear result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("clear in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        checkOutput("after clear spl_clear", 32'(spl_clear), 32'd0);
        checkOutput("after clear in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("after clear split_count", 32'(bus.split_count), 32'd0);
        checkOutput("after clear error", 32'(bus.error), 32'd0);

        // Reset during the third sweep cycle.
        t = "..S..\n..^..\n.....";
        applyStimulus(t);
        checkOutput("drain spl_en", 32'(spl_en), 32'd1);
        repeat (3) @(negedge clock);
        checkOutput("sum3 spl_en", 32'(spl_en), 32'd1);
        checkOutput("sum3 spl_split", 32'(spl_split), 32'd0);
        checkOutput("sum3 split_count", 32'(bus.split_count), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid reset result_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("mid reset spl_en", 32'(spl_en), 32'd0);
        checkOutput("mid reset result", 32'(bus.result), 32'd0);
        checkOutput("mid reset split_count", 32'(bus.split_count), 32'd0);
        stable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (spl_en !== 1'b0 || bus.result_valid !== 1'b0) stable = 1'b0;
        end
        checkOutput("mid reset quiet", 32'(stable), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beam_stream_driver.md
BEAM_STREAM_DRIVER -- requirements
Module: beam_stream_driver

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 141, meaning grid columns per line (odd, >=3).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, meaning width of count, split and result values.
REQ-003 SHALL have clock, 1-bit input: clock; all logic on posedge.
REQ-004 SHALL have reset, 1-bit input: reset, synchronous, active-high.
REQ-005 SHALL have in_valid, in_ready, in_last (1-bit) and in_byte [7:0]: ASCII grid byte stream; in_ready is an output; a byte is accepted when in_valid && in_ready.
REQ-006 SHALL have outputs spl_en, spl_split and spl_clear (1-bit) to drive the downstream beam splitter's en, split_in and reset.
REQ-007 SHALL have count_in [DATA_WIDTH-1:0], input: the splitter's current-column beam count.
REQ-008 SHALL have result [DATA_WIDTH-1:0], split_count [DATA_WIDTH-1:0], result_valid (outputs), result_ready (input) and error (1-bit output, sticky).

Function
REQ-009 SHALL implement states RUN, DRAIN, SUM, DONE and CLEAR; in_ready=1 only in RUN.
REQ-010 SHALL decode each accepted byte: '.' (0x2E) and 'S' (0x53) give split=0; '^' (0x5E) gives split=1; each produces one column step.
REQ-011 SHALL register spl_en=1 and spl_split=split in the cycle after a column byte is accepted: latency 1, one pulse per byte.
REQ-012 SHALL keep a column counter col (0..LINE_LENGTH) that increments per column byte and clears on '\n' (0x0A).
REQ-013 SHALL set error on '\n' when col != LINE_LENGTH; spl_en is not pulsed for '\n'.
REQ-014 SHALL ignore '\r' (0x0D) completely.
REQ-015 SHALL treat any other byte as '.' and set error.
REQ-016 SHALL, for a column byte accepted when col == LINE_LENGTH, set error, generate no spl_en and leave col unchanged.
REQ-017 SHALL set error when 'S' arrives at col != LINE_LENGTH/2 or on any line other than the first.
REQ-018 SHALL increment split_count (mod 2^DATA_WIDTH) in any RUN-phase cycle with spl_en && spl_split && count_in != 0.
REQ-019 SHALL on in_last process the byte normally, then set error if col (after that byte) is neither 0 nor LINE_LENGTH, then enter DRAIN.
REQ-020 SHALL spend exactly 1 cycle in DRAIN, during which the last byte's pulse is issued, then enter SUM.
REQ-021 SHALL in SUM drive spl_en=1, spl_split=0 for exactly LINE_LENGTH consecutive cycles.
REQ-022 SHALL in each SUM cycle add count_in to result (mod 2^DATA_WIDTH), with result cleared on SUM entry, then enter DONE.
REQ-023 SHALL in DONE hold result_valid=1 with result, split_count and error stable until result_ready=1.
REQ-024 SHALL on the DONE handshake enter CLEAR, where spl_clear=1 for exactly 1 cycle and result_valid=0.
REQ-025 SHALL on leaving CLEAR zero split_count, col and error, then enter RUN.
REQ-026 SHALL drive spl_en=0 outside the cycles defined in REQ-011 and REQ-021.

Reset
REQ-027 SHALL on reset enter RUN and zero col, result, split_count, error, result_valid, spl_en, spl_split and spl_clear.
REQ-028 SHALL abandon any state on reset mid-operation (including SUM/DONE) with no further spl_en pulses; the downstream splitter is reset by the same reset.

Verification (LINE_LENGTH=5)
REQ-029 SHALL cover "..S..\n", "..^..\n", then "....." with in_last -> exactly 15 spl_en pulses in RUN and 5 in SUM; result=2, split_count=1, error=0.
REQ-030 SHALL cover "..S..\n", "..^..\n", then ".^.^.\n" with in_last -> result=4, split_count=3, error=0.
REQ-031 SHALL cover "..S..\n", "^....\n" (^ with no beam) -> split_count=0, result=1.
REQ-032 SHALL cover "....\n" (short line) -> error=1, still reaches DONE; 'x' byte -> treated as '.', error=1.
REQ-033 SHALL cover result_ready held low 10 cycles in DONE -> result_valid and result stable; on handshake, spl_clear high exactly 1 cycle, then in_ready=1.
REQ-034 SHALL cover reset asserted on the 3rd SUM cycle -> next cycle in_ready=1, result_valid=0, spl_en=0, result=0, split_count=0.
